// File: rtl/multi_phase_traffic_controller_if.sv
// Lamp/sensor bus of one intersection controller; master = controller, slave = field side.
// ped_countdown is present only when PED_COUNTDOWN_EN is defined.
interface multi_phase_traffic_controller_if #(
  parameter int NUM_PHASES = 4,
  parameter int TIMER_W    = 9
);
  localparam int PHASE_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic [NUM_PHASES-1:0]   sensor;
  logic                    ped_req;
  logic [2*NUM_PHASES-1:0] light;
  logic [1:0]              pedestrian_signal;
  logic [PHASE_W-1:0]      active_phase;
  logic                    ped_pending;
`ifdef PED_COUNTDOWN_EN
  logic [TIMER_W-1:0]      ped_countdown;
`endif

  modport master (
    input  sensor, ped_req,
    output light, pedestrian_signal, active_phase, ped_pending
`ifdef PED_COUNTDOWN_EN
    , output ped_countdown
`endif
  );

  modport slave (
    output sensor, ped_req,
    input  light, pedestrian_signal, active_phase, ped_pending
`ifdef PED_COUNTDOWN_EN
    , input ped_countdown
`endif
  );
endinterface

// File: rtl/multi_phase_traffic_controller.sv
// N-phase intersection controller: round-robin green with demand skip, sensor extension, all-red, WALK.
// Outputs decode registered state only (no input-to-output path); PED_COUNTDOWN_EN adds ped_countdown.
module multi_phase_traffic_controller #(
  parameter int NUM_PHASES     = 4,
  parameter int TIMER_W        = 9,
  parameter int GREEN_DEFAULT  = 30,
  parameter int GREEN_EXTENDED = 45,
  parameter int YELLOW_TIME    = 5,
  parameter int ALL_RED_TIME   = 2,
  parameter int PED_TIME       = 15
) (
  input  logic clk,
  input  logic reset_n,
  multi_phase_traffic_controller_if.master tc
);
  localparam int PHASE_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [TIMER_W-1:0] GD_T = TIMER_W'(GREEN_DEFAULT);
  localparam logic [TIMER_W-1:0] GE_T = TIMER_W'(GREEN_EXTENDED);
  localparam logic [TIMER_W-1:0] YL_T = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] AR_T = TIMER_W'(ALL_RED_TIME);
  localparam logic [TIMER_W-1:0] PD_T = TIMER_W'(PED_TIME);
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] PED_WALK    = 2'b11;

  if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
    $error("NUM_PHASES must be within 2..8");
  end
  if (GREEN_EXTENDED < GREEN_DEFAULT) begin : g_bad_green
    $error("GREEN_EXTENDED must be >= GREEN_DEFAULT");
  end
  if (GREEN_EXTENDED >= (1 << TIMER_W) || GREEN_DEFAULT >= (1 << TIMER_W) ||
      YELLOW_TIME >= (1 << TIMER_W) || ALL_RED_TIME >= (1 << TIMER_W) ||
      PED_TIME >= (1 << TIMER_W)) begin : g_bad_timer_w
    $error("TIMER_W too narrow for a terminal count");
  end

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_PED     = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, term;
  logic [PHASE_W-1:0] cur_q, cur_d, nxt_q, nxt_d, demand_phase, idx;
  logic               pend_q, pend_d, done;

  // Nearest demanded phase after cur (cur itself excluded); plain successor if none.
  always_comb begin
    demand_phase = PHASE_W'((int'(cur_q) + 1) % NUM_PHASES);
    idx          = '0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      idx = PHASE_W'((int'(cur_q) + k) % NUM_PHASES);
      if (tc.sensor[idx]) demand_phase = idx;
    end
  end

  always_comb begin
    term = '0;
    case (state_q)
      ST_GREEN:   term = tc.sensor[cur_q] ? GE_T : GD_T;
      ST_YELLOW:  term = YL_T;
      ST_ALL_RED: term = AR_T;
      ST_PED:     term = PD_T;
      default:    term = '0;
    endcase
  end

  // >= rather than == so a sensor drop late in an extended green exits at once.
  assign done = (timer_q >= term);

  always_comb begin
    state_d = state_q;
    timer_d = done ? '0 : timer_q + 1'b1;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    case (state_q)
      ST_GREEN:  if (done) state_d = ST_YELLOW;
      ST_YELLOW: if (done) begin
        state_d = ST_ALL_RED;
        nxt_d   = demand_phase;
      end
      ST_ALL_RED: if (done) begin
        if (pend_q) state_d = ST_PED;
        else begin
          state_d = ST_GREEN;
          cur_d   = nxt_q;
        end
      end
      ST_PED: if (done) begin
        state_d = ST_GREEN;
        cur_d   = nxt_q;
      end
      default: begin
        state_d = ST_ALL_RED;
        timer_d = '0;
        cur_d   = '0;
        nxt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (state_q != ST_PED) begin
      if (state_d == ST_PED) pend_d = 1'b0;
      else                   pend_d = pend_q | tc.ped_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ALL_RED;
      timer_q <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    tc.light = '0;
    if (state_q == ST_GREEN)  tc.light[2*cur_q +: 2] = LAMP_GREEN;
    if (state_q == ST_YELLOW) tc.light[2*cur_q +: 2] = LAMP_YELLOW;
    tc.pedestrian_signal = (state_q == ST_PED) ? PED_WALK : 2'b00;
    tc.active_phase = (state_q == ST_GREEN || state_q == ST_YELLOW) ? cur_q : nxt_q;
    tc.ped_pending  = pend_q;
`ifdef PED_COUNTDOWN_EN
    tc.ped_countdown = (state_q == ST_PED) ? PD_T - timer_q : '0;
`endif
  end
endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed bench for multi_phase_traffic_controller (4 phases, default timing).
// Samples outputs 1 time unit after each rising edge and drives inputs at the same point.
module tb_multi_phase_traffic_controller;
  localparam int NP = 4;
  localparam int TW = 9;
  localparam logic [1:0] L_G  = 2'b01;
  localparam logic [1:0] L_Y  = 2'b10;
  localparam logic [1:0] DONT = 2'b00;
  localparam logic [1:0] WALK = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  multi_phase_traffic_controller_if #(.NUM_PHASES(NP), .TIMER_W(TW)) tif();

  multi_phase_traffic_controller #(
    .NUM_PHASES(NP), .TIMER_W(TW), .GREEN_DEFAULT(30), .GREEN_EXTENDED(45),
    .YELLOW_TIME(5), .ALL_RED_TIME(2), .PED_TIME(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tc(tif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lamp(input int p, input logic [1:0] code);
    lamp = 8'(code) << (2 * p);
  endfunction

  // Checks n consecutive cycles of one expected output pattern, then advances.
  task automatic dwell(input string tag, input logic [7:0] lt, input logic [1:0] ps,
                       input logic pend, input int act, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].light", tag, i), 32'(tif.light), 32'(lt));
      chk($sformatf("%s[%0d].ped",   tag, i), 32'(tif.pedestrian_signal), 32'(ps));
      chk($sformatf("%s[%0d].pend",  tag, i), 32'(tif.ped_pending), 32'(pend));
      chk($sformatf("%s[%0d].phase", tag, i), 32'(tif.active_phase), 32'(act));
`ifdef PED_COUNTDOWN_EN
      chk($sformatf("%s[%0d].cd", tag, i), 32'(tif.ped_countdown),
          (ps == WALK) ? 32'(15 - i) : 32'd0);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".light"}, 32'(tif.light), 32'd0);
    chk({tag, ".ped"},   32'(tif.pedestrian_signal), 32'd0);
    chk({tag, ".pend"},  32'(tif.ped_pending), 32'd0);
    chk({tag, ".phase"}, 32'(tif.active_phase), 32'd0);
`ifdef PED_COUNTDOWN_EN
    chk({tag, ".cd"},    32'(tif.ped_countdown), 32'd0);
`endif
  endtask

  initial begin
    tif.sensor  = '0;
    tif.ped_req = 1'b0;
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // No demand: plain rotation 0,1,2,3 then back to 0.
    dwell("t1.ar", 8'h00, DONT, 1'b0, 0, 3);
    for (int p = 0; p < NP; p++) begin
      dwell("t1.g", lamp(p, L_G), DONT, 1'b0, p, 31);
      dwell("t1.y", lamp(p, L_Y), DONT, 1'b0, p, 6);
      if (p == NP - 1) tif.sensor = 4'b0001;
      dwell("t1.ar", 8'h00, DONT, 1'b0, (p + 1) % NP, 3);
    end

    // Extended green, then only cur demanded -> plain successor.
    dwell("t2.g0ext", lamp(0, L_G), DONT, 1'b0, 0, 46);
    dwell("t3.y0",    lamp(0, L_Y), DONT, 1'b0, 0, 6);
    dwell("t3.ar1",   8'h00,        DONT, 1'b0, 1, 3);
    dwell("t3.g1",    lamp(1, L_G), DONT, 1'b0, 1, 31);
    dwell("t3.y1",    lamp(1, L_Y), DONT, 1'b0, 1, 6);
    dwell("t3.ar0",   8'h00,        DONT, 1'b0, 0, 3);

    // Sensor drop at timer 35 ends green; phase 3 demand skips 1 and 2.
    dwell("t2.g0",     lamp(0, L_G), DONT, 1'b0, 0, 35);
    tif.sensor = 4'b1000;
    dwell("t2.g0drop", lamp(0, L_G), DONT, 1'b0, 0, 1);
    dwell("t2.y0",     lamp(0, L_Y), DONT, 1'b0, 0, 6);
    dwell("t3.ar3",    8'h00,        DONT, 1'b0, 3, 3);
    dwell("t3.g3ext",  lamp(3, L_G), DONT, 1'b0, 3, 46);
    tif.sensor = '0;
    dwell("t3.y3",     lamp(3, L_Y), DONT, 1'b0, 3, 6);
    dwell("t3.ar0b",   8'h00,        DONT, 1'b0, 0, 3);
    dwell("t3.g0",     lamp(0, L_G), DONT, 1'b0, 0, 31);
    dwell("t3.y0b",    lamp(0, L_Y), DONT, 1'b0, 0, 6);
    dwell("t3.ar1b",   8'h00,        DONT, 1'b0, 1, 3);
    dwell("t3.g1b",    lamp(1, L_G), DONT, 1'b0, 1, 31);
    dwell("t3.y1b",    lamp(1, L_Y), DONT, 1'b0, 1, 6);
    dwell("t3.ar2",    8'h00,        DONT, 1'b0, 2, 3);

    // One-cycle pedestrian pulse during phase 2 green.
    dwell("t4.g2a", lamp(2, L_G), DONT, 1'b0, 2, 5);
    tif.ped_req = 1'b1;
    dwell("t4.g2b", lamp(2, L_G), DONT, 1'b0, 2, 1);
    tif.ped_req = 1'b0;
    dwell("t4.g2c", lamp(2, L_G), DONT, 1'b1, 2, 25);
    dwell("t4.y2",  lamp(2, L_Y), DONT, 1'b1, 2, 6);
    dwell("t4.ar",  8'h00,        DONT, 1'b1, 3, 3);
    dwell("t4.walk", 8'h00,       WALK, 1'b0, 3, 16);
    dwell("t4.g3",  lamp(3, L_G), DONT, 1'b0, 3, 31);

    // Request held through WALK: re-latched only after WALK exits.
    tif.ped_req = 1'b1;
    dwell("t5.y3a", lamp(3, L_Y), DONT, 1'b0, 3, 1);
    dwell("t5.y3b", lamp(3, L_Y), DONT, 1'b1, 3, 5);
    dwell("t5.ar",  8'h00,        DONT, 1'b1, 0, 3);
    dwell("t5.walk", 8'h00,       WALK, 1'b0, 0, 16);
    dwell("t5.g0a", lamp(0, L_G), DONT, 1'b0, 0, 1);
    tif.ped_req = 1'b0;
    dwell("t5.g0b", lamp(0, L_G), DONT, 1'b1, 0, 30);
    dwell("t5.y0",  lamp(0, L_Y), DONT, 1'b1, 0, 6);
    dwell("t5.ar1", 8'h00,        DONT, 1'b1, 1, 3);
    dwell("t5.walk2", 8'h00,      WALK, 1'b0, 1, 16);
    dwell("t5.g1",  lamp(1, L_G), DONT, 1'b0, 1, 31);

    // Asynchronous reset in the middle of phase 1 yellow with a request latched.
    tif.ped_req = 1'b1;
    dwell("t6.y1a", lamp(1, L_Y), DONT, 1'b0, 1, 1);
    tif.ped_req = 1'b0;
    dwell("t6.y1b", lamp(1, L_Y), DONT, 1'b1, 1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t6.async");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    dwell("t6.ar", 8'h00,        DONT, 1'b0, 0, 3);
    dwell("t6.g0", lamp(0, L_G), DONT, 1'b0, 0, 31);
    dwell("t6.y0", lamp(0, L_Y), DONT, 1'b0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
